// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder on a word-organised RAM.
// One request at a time; an access that crosses a word boundary takes a
// second RAM cycle. A response pulse follows every accepted request.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready; on accept read/write first word, capture request
// S_SECOND | read/write word i+1 for a word-crossing access
// S_RESP   | one-cycle response with assembled load data / error flag
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_SECOND, S_RESP} state_t;

  state_t r_state, w_next;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          r_we;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_lane_hi;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_word0;
  logic [31:0]   r_word1;

  logic          w_idle;
  logic          w_accept;
  logic [1:0]    w_off;
  logic [2:0]    w_size;
  logic [3:0]    w_be_base;
  logic [31:0]   w_mask;
  logic          w_f3_ok;
  logic [32:0]   w_last;
  logic          w_err;
  logic          w_cross;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_idx_next;
  logic [63:0]   w_lane64;
  logic [7:0]    w_be8;
  logic [31:0]   w_ld_src;
  logic [31:0]   w_ld;

  // Handshake is gated by reset so nothing is accepted or reported while rst is high.
  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign req_ready = w_idle;
  assign w_accept  = req_valid && w_idle;
  assign rsp_valid = (r_state == S_RESP) && !rst;

  assign w_off      = req_addr[1:0];
  assign w_idx      = req_addr[AW+1:2];
  assign w_idx_next = r_idx + AW'(1);

  // Decode access size, byte-enable and data masks from funct3.
  always_comb begin
    w_size    = 3'd4;
    w_be_base = 4'b1111;
    w_mask    = 32'hFFFF_FFFF;
    case (req_funct3[1:0])
      2'd0: begin w_size = 3'd1; w_be_base = 4'b0001; w_mask = 32'h0000_00FF; end
      2'd1: begin w_size = 3'd2; w_be_base = 4'b0011; w_mask = 32'h0000_FFFF; end
      default: ;
    endcase
  end

  // Legal funct3 differs between loads and stores.
  always_comb begin
    w_f3_ok = 1'b0;
    if (req_we) w_f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    else        w_f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                          (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
  end

  // Last touched byte computed in 33 bits so the top of the address space cannot wrap.
  assign w_last  = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
  assign w_err   = !w_f3_ok || (w_last >= LIMIT);
  assign w_cross = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;

  // Lanes 0..3 land in word i, lanes 4..7 overflow into word i+1.
  assign w_lane64 = {32'd0, req_wdata & w_mask} << {w_off, 3'b000};
  assign w_be8    = {4'd0, w_be_base} << w_off;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_cross && !w_err) ? S_SECOND : S_RESP;
      S_SECOND: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Capture the request at acceptance and the RAM words it reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_off     <= 2'd0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_lane_hi <= 32'd0;
      r_be_hi   <= 4'd0;
      r_word0   <= 32'd0;
      r_word1   <= 32'd0;
    end else if (w_accept) begin
      r_we      <= req_we;
      r_funct3  <= req_funct3;
      r_off     <= w_off;
      r_err     <= w_err;
      r_idx     <= w_idx;
      r_lane_hi <= w_lane64[63:32];
      r_be_hi   <= w_be8[7:4];
      r_word0   <= r_mem[w_idx];
    end else if (r_state == S_SECOND) begin
      r_word1   <= r_mem[w_idx_next];
    end
  end

  // RAM byte writes: first-word lanes at acceptance, overflow lanes in SECOND. Not reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be8[b]) r_mem[w_idx][8*b +: 8] <= w_lane64[8*b +: 8];
    end
    if (!rst && (r_state == S_SECOND) && r_we) begin
      for (int b = 0; b < 4; b++)
        if (r_be_hi[b]) r_mem[w_idx_next][8*b +: 8] <= r_lane_hi[8*b +: 8];
    end
  end

  // Shift the captured word pair so the addressed byte lands in bits [7:0].
  assign w_ld_src = 32'({r_word1, r_word0} >> {r_off, 3'b000});

  // Sign/zero extension by load type.
  always_comb begin
    w_ld = 32'd0;
    case (r_funct3)
      3'd0: w_ld = {{24{w_ld_src[7]}}, w_ld_src[7:0]};
      3'd1: w_ld = {{16{w_ld_src[15]}}, w_ld_src[15:0]};
      3'd2: w_ld = w_ld_src;
      3'd4: w_ld = {24'd0, w_ld_src[7:0]};
      3'd5: w_ld = {16'd0, w_ld_src[15:0]};
      default: w_ld = 32'd0;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_ld : 32'd0;
  assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table of requests with expected responses; a monitor
// pops the expected-response queue on every rsp_valid pulse.
module tb_dmem_responder;

  localparam int D = 1024;
  localparam logic [31:0] TOP = 32'(4 * D);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    bit          hold;
  } vec_t;
  vec_t tbl[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check32("rsp_rdata", rsp_rdata, e.rdata);
          check32("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check32("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end else begin
        check32("idle_rdata", rsp_rdata, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input vec_t v);
    int n;
    wait_ready();
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    q.push_back('{v.exp_rdata, v.exp_err, cyc, v.lat});
    @(negedge clk);
    if (v.hold) begin
      // Request still presented while busy must be ignored.
      req_we    = ~v.we;
      req_addr  = 32'h0000_0040;
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got no response expected one within 20 cycles");
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               we   f3    addr            wdata          exp_rdata      err  lat hold
    tbl.push_back('{1'b1, 3'd2, 32'h10,         32'hDEADBEEF, 32'h0,         1'b0, 1, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h10,         32'h0,        32'hDEADBEEF,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd0, 32'h13,         32'h0,        32'hFFFFFFDE,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd4, 32'h13,         32'h0,        32'h000000DE,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd1, 32'h12,         32'h0,        32'hFFFFDEAD,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd5, 32'h12,         32'h0,        32'h0000DEAD,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd0, 32'h10,         32'h0,        32'hFFFFFFEF,  1'b0, 1, 0});
    tbl.push_back('{1'b1, 3'd0, 32'h11,         32'h123456AA, 32'h0,         1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h10,         32'h0,        32'hDEADAAEF,  1'b0, 1, 0});
    tbl.push_back('{1'b1, 3'd2, 32'h0E,         32'h11223344, 32'h0,         1'b0, 2, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h0E,         32'h0,        32'h11223344,  1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h10,         32'h0,        32'hDEAD1122,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd1, 32'h0F,         32'h0,        32'h00002233,  1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd3, 32'h00,         32'h0,        32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd2, TOP - 32'd4,    32'h5A5A5A5A, 32'h0,         1'b0, 1, 0});
    tbl.push_back('{1'b1, 3'd2, TOP - 32'd2,    32'hFFFFFFFF, 32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b0, 3'd2, TOP - 32'd4,    32'h0,        32'h5A5A5A5A,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd0, TOP - 32'd1,    32'h0,        32'h0000005A,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd1, TOP - 32'd1,    32'h0,        32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd4, 32'h00,         32'h12345678, 32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b0, 3'd6, 32'h00,         32'h0,        32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd2, 32'hFFFFFFFE,   32'h55555555, 32'h0,         1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd2, 32'h14,         32'h80706050, 32'h0,         1'b0, 1, 0});
    tbl.push_back('{1'b1, 3'd1, 32'h13,         32'hFFFF9988, 32'h0,         1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h14,         32'h0,        32'h80706099,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h10,         32'h0,        32'h88AD1122,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd0, 32'h17,         32'h0,        32'hFFFFFF80,  1'b0, 1, 0});
    tbl.push_back('{1'b0, 3'd5, 32'h13,         32'h0,        32'h00009988,  1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd1, 32'h13,         32'h0,        32'hFFFF9988,  1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h12,         32'h0,        32'h609988AD,  1'b0, 2, 0});
    tbl.push_back('{1'b1, 3'd2, 32'h0C,         32'h01020304, 32'h0,         1'b0, 1, 0});

    // Reset state.
    repeat (2) @(negedge clk);
    check32("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("ready_after_rst", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);

    // Reset during the SECOND cycle of a crossing store.
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0E;
    req_wdata  = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    check32("mid_rst_ready_second", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check32("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check32("mid_rst_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check32("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    issue('{1'b0, 3'd2, 32'h0C, 32'h0, 32'hCCDD0304, 1'b0, 1, 0});
    issue('{1'b0, 3'd2, 32'h10, 32'h0, 32'h88AD1122, 1'b0, 1, 0});

    // Quiet period: any stray response is caught by the monitor.
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
